// File: rtl/pe_ctx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pe_ctx_sequencer
//  Purpose  : Context-memory sequencer for a processing element. Holds a small
//             program of PE control words, replays slots 0..ctx_len for
//             loop_cnt passes, and advances one slot per completed PE
//             operation (handshake on data_valid / pe_output_ready).
//  Ports    : clk, reset (async, active-low)
//             cfg_we/cfg_addr/cfg_data   - context memory write port
//             ctx_len, loop_cnt, start   - run setup, latched on start
//             abort                      - cancel an active run
//             data_valid, pe_output_ready- operand / result handshake
//             ctrl, en, input_ready      - drive to the PE
//             busy, done, cfg_err, step_cnt - status
//  Revision : 1.0 - initial release
// ============================================================================
module pe_ctx_sequencer #(
    parameter int CTRL_WIDTH = 13,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [CTRL_WIDTH-1:0] cfg_data,
    input  logic [ADDR_W-1:0]     ctx_len,
    input  logic [7:0]            loop_cnt,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  data_valid,
    input  logic                  pe_output_ready,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  en,
    output logic                  input_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [15:0]           step_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CTRL_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_pc;
    logic [ADDR_W-1:0]     r_ctx_len;
    logic [7:0]            r_iter;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic                  r_cfg_err;
    logic [15:0]           r_step_cnt;
    logic                  w_start_ok;
    logic                  w_step;
    logic [ADDR_W-1:0]     w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign ctrl     = r_ctrl;
    assign cfg_err  = r_cfg_err;
    assign step_cnt = r_step_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and PE-facing outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_step      = 1'b0;
        en          = 1'b0;
        input_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero pass count is a no-op request: no run, no done.
                if (start && (loop_cnt != 8'd0)) begin
                    w_start_ok = 1'b1;
                    w_next     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                en          = 1'b1;
                busy        = 1'b1;
                input_ready = data_valid;
                // Abort dominates a coincident step: no state or count update.
                if (abort) begin
                    w_next = S_IDLE;
                end else if (data_valid && pe_output_ready) begin
                    w_step = 1'b1;
                    if ((r_pc == r_ctx_len) && (r_iter == 8'd1)) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Context memory, program counter, pass counter and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pc       <= '0;
            r_ctx_len  <= '0;
            r_iter     <= '0;
            r_ctrl     <= '0;
            r_cfg_err  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            // Program memory is only writable while no run is active.
            if (cfg_we) begin
                if (r_state == S_ISSUE) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_mem[cfg_addr] <= cfg_data;
                end
            end

            if (w_start_ok) begin
                r_ctx_len  <= ctx_len;
                r_iter     <= loop_cnt;
                r_pc       <= '0;
                r_step_cnt <= '0;
                r_cfg_err  <= 1'b0;
                // Same-cycle write to slot 0 must reach the first control word.
                if (cfg_we && (cfg_addr == '0)) begin
                    r_ctrl <= cfg_data;
                end else begin
                    r_ctrl <= r_mem[0];
                end
            end else if (w_step) begin
                if (r_step_cnt != 16'hFFFF) begin
                    r_step_cnt <= r_step_cnt + 16'd1;
                end
                if (r_pc < r_ctx_len) begin
                    r_pc   <= w_pc_inc;
                    r_ctrl <= r_mem[w_pc_inc];
                end else if (r_iter > 8'd1) begin
                    r_iter <= r_iter - 8'd1;
                    r_pc   <= '0;
                    r_ctrl <= r_mem[0];
                end
            end
        end
    end

endmodule
`default_nettype wire
